// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a shared single-access RAM.
// Data port wins by default; a starved fetch is forced through after STARVE_LIMIT lost cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  localparam int unsigned CntWidth = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntWidth-1:0] StarveMax = CntWidth'(STARVE_LIMIT);

  logic [CntWidth-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  starved, grant_i, grant_d, grant_ld, grant_st;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  i_rsp_valid_q, d_rsp_valid_q;
  logic [DATA_WIDTH-1:0] i_rsp_data_q, i_rsp_data_d, d_rsp_data_q, d_rsp_data_d;

  always_comb begin
    starved = i_req_valid && (starve_cnt_q == StarveMax);
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (d_req_valid && !starved) begin
        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end
    end
    grant_ld = grant_d && !d_req_we;
    grant_st = grant_d && d_req_we;
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req_valid || grant_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + CntWidth'(1);
    end
  end

  // RAM address/data follow the granted port and otherwise hold the last driven value.
  always_comb begin
    r_addr_d     = r_addr_q;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    i_rsp_data_d = i_rsp_data_q;
    d_rsp_data_d = d_rsp_data_q;
    if (grant_i) begin
      r_addr_d     = i_req_addr;
      i_rsp_data_d = ram_r_data;
    end
    if (grant_ld) begin
      r_addr_d     = d_req_addr;
      d_rsp_data_d = ram_r_data;
    end
    if (grant_st) begin
      w_addr_d = d_req_addr;
      w_data_d = d_req_wdata;
    end
  end

  // Outputs are forced to zero while reset is held, which also squashes an in-flight response.
  always_comb begin
    ram_r_addr  = rst ? '0 : r_addr_d;
    ram_w_addr  = rst ? '0 : w_addr_d;
    ram_w_data  = rst ? '0 : w_data_d;
    ram_we      = grant_st;
    i_rsp_valid = i_rsp_valid_q && !rst;
    d_rsp_valid = d_rsp_valid_q && !rst;
    i_rsp_data  = rst ? '0 : i_rsp_data_q;
    d_rsp_data  = rst ? '0 : d_rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q  <= '0;
      r_addr_q      <= '0;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_data_q  <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      r_addr_q      <= r_addr_d;
      w_addr_q      <= w_addr_d;
      w_data_q      <= w_data_d;
      i_rsp_valid_q <= grant_i;
      d_rsp_valid_q <= grant_ld;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a RAM model and a reference memory/grant model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid, i_req_ready, i_rsp_valid;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_rsp_data;
  logic [AW-1:0] ram_r_addr, ram_w_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
  logic          ram_we;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_we(ram_we), .ram_r_data(ram_r_data)
  );

  // RAM model: 256 words indexed by the low address byte, combinational read.
  logic [DW-1:0] mem [256];
  assign ram_r_data = mem[ram_r_addr[7:0]];

  typedef struct {int at; logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} stim_t;
  typedef struct {int cyc; logic [DW-1:0] data;} exp_t;
  stim_t i_stim[$];
  stim_t d_stim[$];
  exp_t  i_exp[$];
  exp_t  d_exp[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic          i_acc_f = 1'b0, d_acc_f = 1'b0, pw_en = 1'b0;
  logic [AW-1:0] pw_addr = '0;
  logic [DW-1:0] pw_data = '0;
  logic [DW-1:0] ref_mem [256];
  int i_acc_n = 0, d_acc_n = 0, we_cnt = 0, d_rsp_n = 0;
  int last_i_acc_cyc = -1, last_d_acc_cyc = -1, last_acc_cyc = -1;
  logic [DW-1:0] last_d_rsp = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] init_word(input int k);
    if (k == 16) return 32'hDEADBEEF;
    return (32'h9E3779B9 * 32'(k)) ^ 32'h5A5A1234;
  endfunction

  task automatic push_i(input int at, input logic [AW-1:0] addr);
    stim_t s;
    s.at = at; s.we = 1'b0; s.addr = addr; s.data = '0;
    i_stim.push_back(s);
  endtask

  task automatic push_d(input int at, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    stim_t s;
    s.at = at; s.we = we; s.addr = addr; s.data = data;
    d_stim.push_back(s);
  endtask

  // Driver: applies RAM writes at the edge, then presents queued requests once due.
  initial begin
    stim_t s;
    for (int k = 0; k < 256; k++) mem[k] = init_word(k);
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    forever begin
      @(posedge clk);
      if (pw_en) mem[pw_addr[7:0]] = pw_data;
      #1;
      if (i_acc_f) i_req_valid = 1'b0;
      if (d_acc_f) d_req_valid = 1'b0;
      if (!i_req_valid && i_stim.size() > 0 && i_stim[0].at <= cyc) begin
        s = i_stim.pop_front();
        i_req_valid = 1'b1; i_req_addr = s.addr;
      end
      if (!d_req_valid && d_stim.size() > 0 && d_stim[0].at <= cyc) begin
        s = d_stim.pop_front();
        d_req_valid = 1'b1; d_req_we = s.we; d_req_addr = s.addr; d_req_wdata = s.data;
      end
    end
  end

  // Monitor / scoreboard with its own grant prediction and reference memory.
  initial begin
    int i_wait;
    logic exp_gi, exp_gd, exp_v;
    logic [AW-1:0] last_raddr, last_waddr;
    logic [DW-1:0] last_wdata, last_i, last_d;
    exp_t e;
    i_wait = 0; last_raddr = '0; last_waddr = '0; last_wdata = '0; last_i = '0; last_d = '0;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    forever begin
      @(negedge clk);
      i_acc_f = i_req_valid && i_req_ready;
      d_acc_f = d_req_valid && d_req_ready;
      pw_en = ram_we; pw_addr = ram_w_addr; pw_data = ram_w_data;
      if (rst) begin
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_i_rsp_valid", i_rsp_valid, 0);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_i_rsp_data", i_rsp_data, 0);
        chk("rst_d_rsp_data", d_rsp_data, 0);
        chk("rst_ram_r_addr", ram_r_addr, 0);
        i_exp.delete(); d_exp.delete();
        i_wait = 0; last_raddr = '0; last_waddr = '0; last_wdata = '0; last_i = '0; last_d = '0;
      end else begin
        exp_gi = 1'b0; exp_gd = 1'b0;
        if (d_req_valid && !(i_req_valid && i_wait >= SL)) exp_gd = 1'b1;
        else if (i_req_valid) exp_gi = 1'b1;
        chk("grant_i", i_req_ready, exp_gi);
        chk("grant_d", d_req_ready, exp_gd);

        exp_v = i_exp.size() > 0 && i_exp[0].cyc == cyc;
        chk("i_rsp_valid", i_rsp_valid, exp_v);
        if (exp_v) begin
          e = i_exp.pop_front();
          if (i_rsp_valid) begin chk("i_rsp_data", i_rsp_data, e.data); last_i = e.data; end
        end else if (!i_rsp_valid) chk("i_rsp_hold", i_rsp_data, last_i);

        exp_v = d_exp.size() > 0 && d_exp[0].cyc == cyc;
        chk("d_rsp_valid", d_rsp_valid, exp_v);
        if (d_rsp_valid) begin d_rsp_n++; last_d_rsp = d_rsp_data; end
        if (exp_v) begin
          e = d_exp.pop_front();
          if (d_rsp_valid) begin chk("d_rsp_data", d_rsp_data, e.data); last_d = e.data; end
        end else if (!d_rsp_valid) chk("d_rsp_hold", d_rsp_data, last_d);

        if (i_acc_f) begin
          chk("i_ram_r_addr", ram_r_addr, i_req_addr);
          chk("i_wait_bound", i_wait <= SL, 1);
          e.cyc = cyc + 1; e.data = ref_mem[i_req_addr[7:0]];
          i_exp.push_back(e);
          last_raddr = i_req_addr; i_acc_n++; last_i_acc_cyc = cyc; last_acc_cyc = cyc;
        end
        if (d_acc_f) begin
          d_acc_n++; last_d_acc_cyc = cyc; last_acc_cyc = cyc;
          if (d_req_we) begin
            chk("st_ram_we", ram_we, 1);
            chk("st_ram_w_addr", ram_w_addr, d_req_addr);
            chk("st_ram_w_data", ram_w_data, d_req_wdata);
            ref_mem[d_req_addr[7:0]] = d_req_wdata;
            last_waddr = d_req_addr; last_wdata = d_req_wdata;
          end else begin
            chk("ld_ram_r_addr", ram_r_addr, d_req_addr);
            chk("ld_ram_we", ram_we, 0);
            e.cyc = cyc + 1; e.data = ref_mem[d_req_addr[7:0]];
            d_exp.push_back(e);
            last_raddr = d_req_addr;
          end
        end
        if (!(d_acc_f && d_req_we)) begin
          chk("ram_we_idle", ram_we, 0);
          chk("w_addr_hold", ram_w_addr, last_waddr);
          chk("w_data_hold", ram_w_data, last_wdata);
        end
        if (!i_acc_f && !(d_acc_f && !d_req_we)) chk("r_addr_hold", ram_r_addr, last_raddr);
        if (ram_we) we_cnt++;
        i_wait = (i_req_valid && !i_acc_f) ? i_wait + 1 : 0;
      end
    end
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    logic idle = 1'b0;
    while (n < limit && !idle) begin
      @(negedge clk); #1;
      n++;
      idle = i_stim.size() == 0 && d_stim.size() == 0 && !i_req_valid && !d_req_valid &&
             i_exp.size() == 0 && d_exp.size() == 0;
    end
    chk("idle_reached", idle, 1);
  endtask

  initial begin
    int t, i0, d0, w0, r0, ti, td;
    logic [AW-1:0] a;
    // Fetch queued during reset: readies stay low, then granted in the first cycle out of reset.
    push_i(0, 32'h10);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    t = cyc;
    wait_idle(50);
    chk("first_fetch_cycle", last_i_acc_cyc, t);

    // Contention: data wins four times, then the starved fetch, then data resumes.
    t = cyc + 2; i0 = i_acc_n; d0 = d_acc_n;
    push_i(t, 32'h40);
    for (int k = 0; k < 6; k++) push_d(t, 1'b0, 32'h80 + 32'(4 * k), '0);
    wait_idle(100);
    chk("starve_i_cycle", last_i_acc_cyc, t + 4);
    chk("starve_d_resume", last_d_acc_cyc, t + 6);
    chk("starve_i_count", i_acc_n - i0, 1);
    chk("starve_d_count", d_acc_n - d0, 6);

    // Store then load to the same address back-to-back.
    t = cyc + 2; w0 = we_cnt; r0 = d_rsp_n;
    push_d(t, 1'b1, 32'h20, 32'h12345678);
    push_d(t + 1, 1'b0, 32'h20, '0);
    wait_idle(50);
    chk("st_ld_we_pulses", we_cnt - w0, 1);
    chk("st_ld_rsp_count", d_rsp_n - r0, 1);
    chk("st_ld_data", last_d_rsp, 32'h12345678);

    // Alternating fetch/data every cycle.
    t = cyc + 2; i0 = i_acc_n; d0 = d_acc_n;
    for (int k = 0; k < 16; k++) begin
      a = $urandom() & 32'hFFFF00FC;
      if (k % 2 == 0) push_i(t + k, a);
      else push_d(t + k, 1'(($urandom() >> 3) & 1), a, $urandom());
    end
    wait_idle(100);
    chk("alt_acc_count", (i_acc_n - i0) + (d_acc_n - d0), 16);
    chk("alt_last_cycle", last_acc_cyc, t + 15);

    // Reset right after a load acceptance squashes its response.
    t = cyc + 2; d0 = d_acc_n; r0 = d_rsp_n;
    push_d(t, 1'b0, 32'h30, '0);
    while (cyc < t + 1) begin @(posedge clk); #1; end
    rst = 1'b1;
    push_i(0, 32'h14);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(50);
    chk("rst_load_accepted", d_acc_n - d0, 1);
    chk("rst_load_no_rsp", d_rsp_n - r0, 0);

    // Random mixed traffic on both ports with colliding addresses.
    ti = cyc + 2; td = cyc + 2;
    for (int k = 0; k < 300; k++) begin
      a = $urandom() & 32'hFFFF003C;
      if ($urandom_range(0, 1) == 0) begin
        push_i(ti, a);
        ti += $urandom_range(0, 2);
      end else begin
        push_d(td, 1'($urandom_range(0, 1)), a, $urandom());
        td += $urandom_range(0, 2);
      end
    end
    wait_idle(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the count of consecutive lost instruction-port cycles that forces an instruction grant.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 i_req_valid  in  1  SHALL be the instruction-fetch read request.
REQ-007 i_req_addr  in  ADDR_WIDTH  SHALL be the fetch byte address.
REQ-008 i_req_ready  out  1  SHALL indicate the fetch request is accepted this cycle.
REQ-009 i_rsp_valid  out  1  SHALL mark valid fetch data on i_rsp_data.
REQ-010 i_rsp_data  out  DATA_WIDTH  SHALL carry the fetched word.
REQ-011 d_req_valid  in  1  SHALL be the load/store request.
REQ-012 d_req_we  in  1  SHALL select store (1) or load (0).
REQ-013 d_req_addr  in  ADDR_WIDTH  SHALL be the load/store byte address.
REQ-014 d_req_wdata  in  DATA_WIDTH  SHALL be the store data.
REQ-015 d_req_ready  out  1  SHALL indicate the data request is accepted this cycle.
REQ-016 d_rsp_valid  out  1  SHALL mark valid load data on d_rsp_data; never asserted for stores.
REQ-017 d_rsp_data  out  DATA_WIDTH  SHALL carry the loaded word.
REQ-018 ram_r_addr, ram_w_addr  out  ADDR_WIDTH; ram_w_data  out  DATA_WIDTH; ram_we  out  1; ram_r_data  in  DATA_WIDTH  SHALL drive the shared single-access RAM, whose read is combinational and write lands on the next rising edge.

Function
REQ-019 At most one of i_req_ready, d_req_ready SHALL be high in any cycle; ready SHALL be combinational from valid, rst and internal state, and SHALL be 0 while rst is high.
REQ-020 A request SHALL be accepted in a cycle where valid and ready are both high; requesters hold valid/addr/data stable until accepted.
REQ-021 Default priority: data port wins when both valid.
REQ-022 Counter starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment each cycle i_req_valid is high and not accepted, saturating at STARVE_LIMIT, and clear on any fetch acceptance or when i_req_valid is low.
REQ-023 When starve_cnt == STARVE_LIMIT and both valid, the instruction port SHALL be granted.
REQ-024 Granted fetch: ram_r_addr = i_req_addr, ram_we = 0; granted load: ram_r_addr = d_req_addr, ram_we = 0; granted store: ram_w_addr = d_req_addr, ram_w_data = d_req_wdata, ram_we = 1.
REQ-025 ram_we SHALL be 0 in every cycle without an accepted store, including during rst.
REQ-026 No grant: ram_r_addr, ram_w_addr, ram_w_data SHALL hold their last driven values (registered mux select), ram_we = 0.
REQ-027 Read latency SHALL be exactly 1 cycle: ram_r_data captured at the acceptance edge, i_rsp_valid/d_rsp_valid high for exactly the following cycle with the captured word.
REQ-028 rsp_data registers SHALL hold their value when the corresponding rsp_valid is low.
REQ-029 Back-to-back acceptances SHALL be supported every cycle with no bubble; rsp_valid of either port MAY be high in consecutive cycles.
REQ-030 A store accepted in cycle N followed by a load to the same address accepted in N+1 SHALL return the stored word (RAM write-before-read ordering, no bypass needed).
REQ-031 Addresses SHALL be forwarded unmodified; alignment is the requester's responsibility.

Reset
REQ-032 rst high at a rising edge SHALL clear starve_cnt, i_rsp_valid, d_rsp_valid, i_rsp_data, d_rsp_data, and held RAM address/data registers to 0.
REQ-033 A read accepted in the cycle before rst asserts SHALL NOT produce a response; rsp_valid SHALL be 0 in the first cycle after rst.
REQ-034 First acceptance SHALL be possible in the first cycle rst is low.

Verification
REQ-035 Fetch only: i_req_valid, addr 0x10, RAM word 0xDEADBEEF -> i_req_ready same cycle, i_rsp_valid + 0xDEADBEEF next cycle.
REQ-036 Both valid, starve_cnt 0 -> d granted; d held valid 6 cycles -> i granted on 5th cycle (STARVE_LIMIT=4), then d resumes.
REQ-037 Store 0x12345678 to 0x20 then load 0x20 back-to-back -> ram_we pulse 1 cycle, d_rsp_data 0x12345678, d_rsp_valid never set for the store.
REQ-038 Alternating i/d requests every cycle -> one acceptance per cycle, responses each 1 cycle later, data matches RAM model.
REQ-039 rst asserted the cycle after a load acceptance -> no d_rsp_valid, all outputs 0, readies 0 during rst.
REQ-040 Random mixed traffic vs. reference memory model -> no dual grant, no lost or duplicated response, no fetch wait > STARVE_LIMIT+1 cycles.
